// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH/DECODE/EXEC control sequencer for the accumulator CPU.
//
// Handles the instruction-fetch handshake and the data-memory write handshake. It keeps a
// bounded data-stack pointer and traps overflow, underflow and illegal opcodes into HALT.
//
// Optional feature: define CTRL_SEQ_PERF_CNT_EN to build the 32-bit retired-instruction
// counter. When it is undefined, instr_count_o is tied to 0.
//
// Opcodes: 0 NOP, 1 LOAD, 2 SET, 3 ADD, 4 MULT, 5 JNZ, 6 JZ, 7 JMP,
//          8 PUSH, 9 POP, 10 SADD, 11 SMLT. Opcodes 12 and above are illegal.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge) and asynchronous active-low reset
//   start_i              leave IDLE/HALT and begin fetching
//   instr_valid_i        instruction memory presents opcode_i this cycle
//   opcode_i             fetched opcode
//   acc_i                signed accumulator value (for the JNZ/JZ tests)
//   mem_ready_i          data memory accepted the write
//   fetch_req_o          request the next instruction
//   pc_inc_o, pc_load_o  advance the PC / load the jump target (mutually exclusive pulses)
//   alu_op_o, acc_load_o ALU operation select and accumulator capture (EXEC only)
//   mem_wr_o             data-memory write strobe
//   data_sp_push_o/pop_o stack push/pop pulses
//   stack_addr_o, sp_o   stack slot address for push/pop; current stack depth
//   halted_o, fault_o    HALT indicator; 0 none, 1 illegal, 2 overflow, 3 underflow
//   instr_count_o        retired-instruction count
module ctrl_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned ALU_OP_WIDTH = 3,
  parameter int unsigned STACK_DEPTH  = 16,
  parameter int unsigned SP_WIDTH     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          instr_valid_i,
  input  logic [OPCODE_WIDTH-1:0]       opcode_i,
  input  logic signed [DATA_WIDTH-1:0]  acc_i,
  input  logic                          mem_ready_i,
  output logic                          fetch_req_o,
  output logic                          pc_inc_o,
  output logic                          pc_load_o,
  output logic [ALU_OP_WIDTH-1:0]       alu_op_o,
  output logic                          acc_load_o,
  output logic                          mem_wr_o,
  output logic                          data_sp_push_o,
  output logic                          data_sp_pop_o,
  output logic [SP_WIDTH-1:0]           stack_addr_o,
  output logic [SP_WIDTH-1:0]           sp_o,
  output logic                          halted_o,
  output logic [1:0]                    fault_o,
  output logic [31:0]                   instr_count_o
);

  localparam logic [OPCODE_WIDTH-1:0] OpNop     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OpLoad    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OpSet     = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OpAdd     = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OpMult    = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OpJnz     = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OpJz      = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OpJmp     = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OpPush    = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OpPop     = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OpSadd    = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OpSmlt    = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OpIllegal = OPCODE_WIDTH'(12);

  localparam logic [1:0] FaultNone      = 2'd0;
  localparam logic [1:0] FaultIllegal   = 2'd1;
  localparam logic [1:0] FaultOverflow  = 2'd2;
  localparam logic [1:0] FaultUnderflow = 2'd3;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] ir_q, ir_d;
  logic [SP_WIDTH-1:0]     sp_q, sp_d;
  logic [1:0]              fault_q, fault_d;
  logic                    retire;
  logic                    exec_done;
  logic                    is_stack_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ir_q    <= '0;
      sp_q    <= '0;
      fault_q <= FaultNone;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  assign is_stack_pop = (ir_q == OpPop) || (ir_q == OpSadd) || (ir_q == OpSmlt);

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    sp_d           = sp_q;
    fault_d        = fault_q;
    retire         = 1'b0;
    exec_done      = 1'b0;
    fetch_req_o    = 1'b0;
    pc_inc_o       = 1'b0;
    pc_load_o      = 1'b0;
    alu_op_o       = '0;
    acc_load_o     = 1'b0;
    mem_wr_o       = 1'b0;
    data_sp_push_o = 1'b0;
    data_sp_pop_o  = 1'b0;
    stack_addr_o   = '0;
    halted_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        fetch_req_o = 1'b1;
        if (instr_valid_i) begin
          ir_d    = opcode_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Faults are resolved here so EXEC never has to back out a stack update.
        if (ir_q >= OpIllegal) begin
          fault_d = FaultIllegal;
          state_d = StHalt;
        end else if ((ir_q == OpPush) && (sp_q == SP_WIDTH'(STACK_DEPTH))) begin
          fault_d = FaultOverflow;
          state_d = StHalt;
        end else if (is_stack_pop && (sp_q == '0)) begin
          fault_d = FaultUnderflow;
          state_d = StHalt;
        end else if (ir_q == OpNop) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        exec_done = 1'b1;
        case (ir_q)
          OpLoad: begin
            alu_op_o   = ALU_OP_WIDTH'(1);
            acc_load_o = 1'b1;
          end
          OpSet: begin
            mem_wr_o  = 1'b1;
            exec_done = mem_ready_i;
          end
          OpAdd: begin
            alu_op_o   = ALU_OP_WIDTH'(2);
            acc_load_o = 1'b1;
          end
          OpMult: begin
            alu_op_o   = ALU_OP_WIDTH'(3);
            acc_load_o = 1'b1;
          end
          OpJnz:   pc_load_o = (acc_i != '0);
          OpJz:    pc_load_o = (acc_i == '0);
          OpJmp:   pc_load_o = 1'b1;
          OpPush: begin
            mem_wr_o       = 1'b1;
            stack_addr_o   = sp_q;
            exec_done      = mem_ready_i;
            data_sp_push_o = mem_ready_i;
            if (mem_ready_i) sp_d = sp_q + SP_WIDTH'(1);
          end
          OpPop, OpSadd, OpSmlt: begin
            alu_op_o      = (ir_q == OpPop)  ? ALU_OP_WIDTH'(1) :
                            (ir_q == OpSadd) ? ALU_OP_WIDTH'(2) : ALU_OP_WIDTH'(3);
            acc_load_o    = 1'b1;
            data_sp_pop_o = 1'b1;
            stack_addr_o  = sp_q - SP_WIDTH'(1);
            sp_d          = sp_q - SP_WIDTH'(1);
          end
          default: ;
        endcase
        if (exec_done) begin
          pc_inc_o = !pc_load_o;
          retire   = 1'b1;
          state_d  = StFetch;
        end
      end
      StHalt: begin
        halted_o = 1'b1;
        if (start_i) begin
          fault_d = FaultNone;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sp_o    = sp_q;
  assign fault_o = fault_q;

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [31:0] instr_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_count_q <= '0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign instr_count_o = instr_count_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer.
// Strobe vector layout: {fetch_req, pc_inc, pc_load, alu_op[2:0], acc_load, mem_wr,
//                        data_sp_push, data_sp_pop, halted}.
module tb_ctrl_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        instr_valid_i;
  logic [3:0]  opcode_i;
  logic signed [31:0] acc_i;
  logic        mem_ready_i;
  logic        fetch_req_o, pc_inc_o, pc_load_o;
  logic [2:0]  alu_op_o;
  logic        acc_load_o, mem_wr_o, data_sp_push_o, data_sp_pop_o;
  logic [4:0]  stack_addr_o, sp_o;
  logic        halted_o;
  logic [1:0]  fault_o;
  logic [31:0] instr_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int retired = 0;

  ctrl_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .instr_valid_i (instr_valid_i),
    .opcode_i      (opcode_i),
    .acc_i         (acc_i),
    .mem_ready_i   (mem_ready_i),
    .fetch_req_o   (fetch_req_o),
    .pc_inc_o      (pc_inc_o),
    .pc_load_o     (pc_load_o),
    .alu_op_o      (alu_op_o),
    .acc_load_o    (acc_load_o),
    .mem_wr_o      (mem_wr_o),
    .data_sp_push_o(data_sp_push_o),
    .data_sp_pop_o (data_sp_pop_o),
    .stack_addr_o  (stack_addr_o),
    .sp_o          (sp_o),
    .halted_o      (halted_o),
    .fault_o       (fault_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  logic [10:0] dut_strb;
  assign dut_strb = {fetch_req_o, pc_inc_o, pc_load_o, alu_op_o, acc_load_o, mem_wr_o,
                     data_sp_push_o, data_sp_pop_o, halted_o};

  function automatic logic [10:0] mk(input logic f, input logic inc, input logic ld,
                                     input logic [2:0] alu, input logic accl, input logic wr,
                                     input logic push, input logic pop, input logic halt);
    return {f, inc, ld, alu, accl, wr, push, pop, halt};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef CTRL_SEQ_PERF_CNT_EN
    return 32'(retired);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called while in FETCH; returns one cycle into whatever follows DECODE.
  task automatic fetch_decode(input logic [3:0] op);
    instr_valid_i = 1'b1;
    opcode_i      = op;
    tick();
    instr_valid_i = 1'b0;
    opcode_i      = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; instr_valid_i = 1'b0; opcode_i = '0;
    acc_i = '0; mem_ready_i = 1'b0;
    #3;
    check_eq("rst_strobes", 32'(dut_strb), 32'd0);
    check_eq("rst_sp", 32'(sp_o), 32'd0);
    check_eq("rst_fault", 32'(fault_o), 32'd0);
    check_eq("rst_count", instr_count_o, 32'd0);
    check_eq("rst_saddr", 32'(stack_addr_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;

    // LOAD: FETCH, DECODE, EXEC, back to FETCH.
    start_i = 1'b1; #1;
    check_eq("idle_strobes", 32'(dut_strb), 32'd0);
    tick(); start_i = 1'b0;
    instr_valid_i = 1'b1; opcode_i = 4'd1; #1;
    check_eq("fetch_strobes", 32'(dut_strb), 32'(mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0)));
    tick(); instr_valid_i = 1'b0; opcode_i = '0; #1;
    check_eq("decode_strobes", 32'(dut_strb), 32'd0);
    tick();
    check_eq("exec_load", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd1, 1, 0, 0, 0, 0)));
    tick(); retired++;
    check_eq("load_refetch", 32'(dut_strb), 32'(mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0)));

    // Conditional and unconditional control flow.
    fetch_decode(4'd5); acc_i = 0; #1;
    check_eq("jnz_acc0", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd0, 0, 0, 0, 0, 0)));
    tick(); retired++;
    fetch_decode(4'd5); acc_i = 5; #1;
    check_eq("jnz_acc5", 32'(dut_strb), 32'(mk(0, 0, 1, 3'd0, 0, 0, 0, 0, 0)));
    tick(); retired++;
    fetch_decode(4'd6); acc_i = 0; #1;
    check_eq("jz_acc0", 32'(dut_strb), 32'(mk(0, 0, 1, 3'd0, 0, 0, 0, 0, 0)));
    tick(); retired++;
    fetch_decode(4'd3); #1;
    check_eq("exec_add", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd2, 1, 0, 0, 0, 0)));
    tick(); retired++;
    check_eq("count_after5", instr_count_o, exp_count());

    // SET with a three-cycle write stall.
    fetch_decode(4'd2); mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("set_wait%0d", i), 32'(dut_strb),
               32'(mk(0, 0, 0, 3'd0, 0, 1, 0, 0, 0)));
      tick();
    end
    mem_ready_i = 1'b1; #1;
    check_eq("set_ready", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd0, 0, 1, 0, 0, 0)));
    tick(); retired++; mem_ready_i = 1'b0;

    // Fill the stack to the top.
    for (int i = 0; i < 16; i++) begin
      fetch_decode(4'd8); mem_ready_i = 1'b1; #1;
      check_eq($sformatf("push_addr%0d", i), 32'(stack_addr_o), 32'(i));
      check_eq($sformatf("push_strb%0d", i), 32'(dut_strb),
               32'(mk(0, 1, 0, 3'd0, 0, 1, 1, 0, 0)));
      tick(); retired++; mem_ready_i = 1'b0;
    end
    check_eq("sp_full", 32'(sp_o), 32'd16);
    fetch_decode(4'd8); mem_ready_i = 1'b1; #1;
    check_eq("ovf_fault", 32'(fault_o), 32'd2);
    check_eq("ovf_strobes", 32'(dut_strb), 32'(mk(0, 0, 0, 3'd0, 0, 0, 0, 0, 1)));
    check_eq("ovf_sp", 32'(sp_o), 32'd16);
    tick(); mem_ready_i = 1'b0;

    // Restart clears the fault; POP from a full stack.
    start_i = 1'b1; tick(); start_i = 1'b0;
    check_eq("restart_fault", 32'(fault_o), 32'd0);
    check_eq("restart_fetch", 32'(dut_strb), 32'(mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0)));
    fetch_decode(4'd9); #1;
    check_eq("pop_addr", 32'(stack_addr_o), 32'd15);
    check_eq("pop_strobes", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd1, 1, 0, 0, 1, 0)));
    tick(); retired++;
    check_eq("pop_sp", 32'(sp_o), 32'd15);
    fetch_decode(4'd10); #1;
    check_eq("sadd_strobes", 32'(dut_strb), 32'(mk(0, 1, 0, 3'd2, 1, 0, 0, 1, 0)));
    tick(); retired++;
    check_eq("count_before_rst", instr_count_o, exp_count());

    // Illegal opcode traps, then restart resumes fetching.
    fetch_decode(4'd12); #1;
    check_eq("illegal_fault", 32'(fault_o), 32'd1);
    check_eq("illegal_halt", 32'(dut_strb), 32'(mk(0, 0, 0, 3'd0, 0, 0, 0, 0, 1)));
    check_eq("illegal_sp", 32'(sp_o), 32'd14);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check_eq("illegal_clear", 32'(fault_o), 32'd0);
    check_eq("illegal_refetch", 32'(dut_strb), 32'(mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0)));

    // Reset during a stalled PUSH.
    fetch_decode(4'd8); mem_ready_i = 1'b0; #1;
    check_eq("stall_push", 32'(dut_strb), 32'(mk(0, 0, 0, 3'd0, 0, 1, 0, 0, 0)));
    rst_ni = 1'b0; #1;
    check_eq("arst_strobes", 32'(dut_strb), 32'd0);
    check_eq("arst_sp", 32'(sp_o), 32'd0);
    check_eq("arst_count", instr_count_o, 32'd0);
    tick(); rst_ni = 1'b1;

    // POP on an empty stack underflows.
    start_i = 1'b1; tick(); start_i = 1'b0;
    fetch_decode(4'd9); #1;
    check_eq("unf_fault", 32'(fault_o), 32'd3);
    check_eq("unf_halt", 32'(dut_strb), 32'(mk(0, 0, 0, 3'd0, 0, 0, 0, 0, 1)));
    check_eq("unf_sp", 32'(sp_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the accumulator CPU; replaces the purely combinational opcode decode with a FETCH/DECODE/EXEC state machine.
- Adds a fetch handshake with instruction memory, a write handshake with data memory, and a bounded data-stack pointer with overflow/underflow detection.
- Adds illegal-opcode trapping and a HALT state.
- Sits between the program counter, the instruction/data memories, the ALU and the accumulator.

Parameters:
- DATA_WIDTH, 32, accumulator width.
- OPCODE_WIDTH, 4, opcode width; must be ≥ 4. Opcodes ≥ 12 are illegal.
- ALU_OP_WIDTH, 3, ALU operation select width.
- STACK_DEPTH, 16, data-stack entries; must be ≥ 2.
- SP_WIDTH, $clog2(STACK_DEPTH+1), stack-pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE/HALT and begin fetching.
- instr_valid  in  1  instruction memory returns opcode this cycle.
- opcode  in  OPCODE_WIDTH  fetched opcode, sampled when fetch_req && instr_valid.
- acc  in  DATA_WIDTH  signed accumulator value.
- mem_ready  in  1  data memory accepted a write.
- fetch_req  out  1  request next instruction.
- pc_inc  out  1  advance PC (1-cycle pulse).
- pc_load  out  1  load jump target (1-cycle pulse).
- alu_op  out  ALU_OP_WIDTH  ALU operation; valid in EXEC only.
- acc_load  out  1  accumulator captures ALU result.
- mem_wr  out  1  data-memory write strobe.
- data_sp_push  out  1  push pulse.
- data_sp_pop  out  1  pop pulse.
- stack_addr  out  SP_WIDTH  stack slot address for push/pop.
- sp  out  SP_WIDTH  current stack depth (0 = empty).
- halted  out  1  sequencer in HALT.
- fault  out  2  0 none, 1 illegal opcode, 2 stack overflow, 3 stack underflow.
- instr_count  out  32  retired-instruction count; see Optional Feature.

Behaviour:
- Reset (async, rst_n low): state=IDLE, sp=0, instruction register=0, fault=0, instr_count=0. All outputs 0.
- IDLE: all strobes 0. On start=1, go to FETCH.
- FETCH: fetch_req=1. When instr_valid=1, latch opcode into the instruction register and go to DECODE. Otherwise stay in FETCH indefinitely.
- DECODE: 1 cycle. Classify the opcode and check for faults.
  - Illegal opcode -> fault=1.
  - PUSH with sp==STACK_DEPTH -> fault=2.
  - POP/SADD/SMLT with sp==0 -> fault=3.
  - Any fault -> HALT; no strobes issued, sp unchanged.
  - NOP (0) -> HALT, fault=0.
  - Otherwise -> EXEC.
- EXEC: issue control strobes for exactly one cycle, except while waiting on mem_ready (see below).
  - LOAD: alu_op=1, acc_load.
  - SET: mem_wr.
  - ADD: alu_op=2, acc_load, mem_wr=0.
  - MULT: alu_op=3, acc_load.
  - JNZ: pc_load = (acc != 0).
  - JZ: pc_load = (acc == 0).
  - JMP: pc_load=1.
  - PUSH: mem_wr, data_sp_push, stack_addr=sp, then sp+1.
  - POP: alu_op=1, acc_load, data_sp_pop, stack_addr=sp-1, then sp-1.
  - SADD: as POP with alu_op=2.
  - SMLT: as POP with alu_op=3.
- pc_inc=1 in the final EXEC cycle whenever pc_load=0. pc_inc and pc_load are mutually exclusive.
- Write wait (SET and PUSH): mem_wr is held and EXEC extends until mem_ready=1. data_sp_push, pc_inc and the sp update occur only in the mem_ready cycle.
- After EXEC: instr_count+1, go to FETCH.
- Latency: minimum 3 cycles per instruction (FETCH with instr_valid already high, DECODE, EXEC).
- HALT: halted=1, all strobes 0, fault held.
  - start=1 clears fault and goes to FETCH.
  - sp and instr_count are preserved.
- alu_op=0 whenever not in EXEC. sp never wraps: over- and underflow are trapped in DECODE.
- Reset mid-EXEC aborts immediately. No partial sp update survives; sp returns to 0.

Optional Feature:
- Macro: CTRL_SEQ_PERF_CNT_EN.
- Defined: instr_count is a 32-bit register.
  - Increments once per retired instruction (EXEC exit).
  - Wraps from 0xFFFFFFFF to 0.
  - Jumps count as retired; NOP and faults do not.
- Undefined: no counter logic; instr_count is tied to 0.

Test Plan:
- Reset then start; fetch LOAD(1) with instr_valid on the first FETCH cycle -> EXEC on cycle 3 with alu_op=1, acc_load=1, pc_inc=1; return to FETCH on cycle 4.
- JNZ with acc=0 -> pc_load=0, pc_inc=1. JNZ with acc=5 -> pc_load=1, pc_inc=0. JZ with acc=0 -> pc_load=1.
- SET with mem_ready low for 3 cycles -> mem_wr high for 4 cycles, pc_inc only in the 4th.
- 16 PUSHes -> sp=16, stack_addr 0..15. 17th PUSH -> fault=2, halted=1, sp stays 16, no push strobe.
- POP at sp=0 -> fault=3, halted. Opcode 4'b1100 -> fault=1. Then start -> fault=0, fetching resumes.
- Assert rst_n low during a stalled PUSH -> all outputs 0, sp=0 asynchronously. With CTRL_SEQ_PERF_CNT_EN defined, 5 retired instructions -> instr_count=5.
